// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between EX and WB.
// Issues loads/stores on the data port and aligns load results.

module mem_stage #(
    parameter int XLEN     = 64,
    parameter int PC_WIDTH = 64,
    parameter int WB_W     = PC_WIDTH + 3*XLEN + 12
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   ex_to_mem_valid,
    output logic                   mem_allow_in,
    input  logic [WB_W+5+XLEN-1:0] ex_to_mem_bus,
    input  logic                   wb_allow_in,
    output logic                   mem_to_wb_valid,
    output logic [WB_W-1:0]        mem_to_wb_bus,
    input  logic                   system_flush,
    output logic                   data_req,
    output logic                   data_wr,
    output logic [7:0]             data_wstrb,
    output logic [XLEN-1:0]        data_addr,
    output logic [XLEN-1:0]        data_wdata,
    input  logic                   data_addr_ok,
    input  logic                   data_data_ok,
    input  logic [XLEN-1:0]        data_rdata
);

    localparam int EX_W = WB_W + 5 + XLEN;
    localparam int LO_W = WB_W - PC_WIDTH - XLEN;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t state;
    state_t state_nx;

    logic            mem_valid;
    logic [EX_W-1:0] mem_reg;
    logic [XLEN-1:0] ld_data;

    logic [PC_WIDTH-1:0] pc;
    logic [XLEN-1:0]     alu_result;
    logic [XLEN-1:0]     store_data;
    logic [LO_W-1:0]     wb_lo;
    logic                rd;
    logic                wr;
    logic                uns;
    logic [1:0]          size;
    logic [2:0]          lane;

    logic is_mem;
    logic in_is_mem;
    logic ready_go;
    logic accept;

    logic [XLEN-1:0] raw;
    logic [XLEN-1:0] ld_ext;
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] wdata_rep;
    logic [7:0]      strb_base;

    assign {pc, alu_result, wb_lo, rd, wr, uns, size, store_data} = mem_reg;

    assign lane      = alu_result[2:0];
    assign is_mem    = rd | wr;
    assign in_is_mem = |ex_to_mem_bus[XLEN+3 +: 2];

    assign ready_go        = !is_mem || (state == S_DONE);
    assign mem_to_wb_valid = mem_valid && ready_go;
    assign mem_allow_in    = (state != S_DRAIN) &&
                             (!mem_valid || (ready_go && wb_allow_in));
    assign accept          = mem_allow_in && ex_to_mem_valid && !system_flush;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_valid <= 1'b0;
            mem_reg   <= '0;
        end else begin
            if (system_flush) begin
                mem_valid <= 1'b0;
            end else if (mem_allow_in) begin
                mem_valid <= ex_to_mem_valid;
            end
            if (accept) begin
                mem_reg <= ex_to_mem_bus;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_data <= '0;
        end else if (state == S_WAIT && data_data_ok) begin
            ld_data <= ld_ext;
        end
    end

    // A request accepted in the flush cycle still owes a response,
    // so it must be drained rather than forgotten.
    always_comb begin
        state_nx = state;
        if (system_flush) begin
            unique case (state)
                S_REQ:   state_nx = data_addr_ok ? S_DRAIN : S_IDLE;
                S_WAIT:  state_nx = data_data_ok ? S_IDLE : S_DRAIN;
                S_DRAIN: state_nx = data_data_ok ? S_IDLE : S_DRAIN;
                default: state_nx = S_IDLE;
            endcase
        end else if (accept) begin
            state_nx = in_is_mem ? S_REQ : S_IDLE;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (data_addr_ok) state_nx = S_WAIT;
                end
                S_WAIT: begin
                    if (data_data_ok) state_nx = S_DONE;
                end
                S_DRAIN: begin
                    if (data_data_ok) state_nx = S_IDLE;
                end
                S_DONE: begin
                    if (mem_allow_in) state_nx = S_IDLE;
                end
                default: state_nx = state;
            endcase
        end
    end

    always_comb begin
        raw    = data_rdata >> {lane, 3'b000};
        ld_ext = raw;
        unique case (size)
            2'd0:    ld_ext = {{(XLEN-8){raw[7] & ~uns}}, raw[7:0]};
            2'd1:    ld_ext = {{(XLEN-16){raw[15] & ~uns}}, raw[15:0]};
            2'd2:    ld_ext = {{(XLEN-32){raw[31] & ~uns}}, raw[31:0]};
            default: ld_ext = raw;
        endcase
    end

    always_comb begin
        strb_base = 8'hff;
        wdata_rep = store_data;
        unique case (size)
            2'd0: begin
                strb_base = 8'h01;
                wdata_rep = {(XLEN/8){store_data[7:0]}};
            end
            2'd1: begin
                strb_base = 8'h03;
                wdata_rep = {(XLEN/16){store_data[15:0]}};
            end
            2'd2: begin
                strb_base = 8'h0f;
                wdata_rep = {(XLEN/32){store_data[31:0]}};
            end
            default: begin
                strb_base = 8'hff;
                wdata_rep = store_data;
            end
        endcase
    end

    assign data_req   = (state == S_REQ);
    assign data_wr    = data_req && wr;
    assign data_wstrb = data_wr ? (strb_base << lane) : 8'h00;
    assign data_addr  = alu_result;
    assign data_wdata = wdata_rep;

    assign result        = rd ? ld_data : alu_result;
    assign mem_to_wb_bus = {pc, result, wb_lo};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: random + directed checks of mem_stage
// against a flag-level behavioural model of the stage.

module tb_mem_stage;

    localparam int XLEN = 64;
    localparam int PCW  = 64;
    localparam int WB_W = PCW + 3*XLEN + 12;
    localparam int EX_W = WB_W + 5 + XLEN;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] alu;
        logic        rf;
        logic [4:0]  wa;
        logic [63:0] cidx;
        logic [3:0]  cc;
        logic [63:0] cdata;
        logic [1:0]  sys;
        logic        rd;
        logic        wr;
        logic        uns;
        logic [1:0]  size;
        logic [63:0] sd;
    } ins_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            ex_to_mem_valid;
    logic            mem_allow_in;
    logic [EX_W-1:0] ex_to_mem_bus;
    logic            wb_allow_in;
    logic            mem_to_wb_valid;
    logic [WB_W-1:0] mem_to_wb_bus;
    logic            system_flush;
    logic            data_req;
    logic            data_wr;
    logic [7:0]      data_wstrb;
    logic [63:0]     data_addr;
    logic [63:0]     data_wdata;
    logic            data_addr_ok;
    logic            data_data_ok;
    logic [63:0]     data_rdata;

    ins_t ex_ins;

    ins_t        m_ins;
    logic        m_valid;
    logic        m_acc;
    logic        m_done;
    logic        m_drain;
    logic [63:0] m_rdata;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mem_stage #(.XLEN(XLEN), .PC_WIDTH(PCW)) dut (
        .clk             (clk),
        .rst             (rst),
        .ex_to_mem_valid (ex_to_mem_valid),
        .mem_allow_in    (mem_allow_in),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .wb_allow_in     (wb_allow_in),
        .mem_to_wb_valid (mem_to_wb_valid),
        .mem_to_wb_bus   (mem_to_wb_bus),
        .system_flush    (system_flush),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_wstrb      (data_wstrb),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata)
    );

    function automatic logic [EX_W-1:0] pack_ex(input ins_t i);
        return {i.pc, i.alu, i.rf, i.wa, i.cidx, i.cc, i.cdata, i.sys,
                i.rd, i.wr, i.uns, i.size, i.sd};
    endfunction

    always_comb ex_to_mem_bus = pack_ex(ex_ins);

    function automatic logic ismem(input ins_t i);
        return i.rd | i.wr;
    endfunction

    function automatic logic [63:0] load_val(input ins_t i, input logic [63:0] rdata);
        int          sh;
        int          nb;
        logic [63:0] v;
        logic [63:0] mask;
        sh   = int'(i.alu[2:0]);
        nb   = 1 << i.size;
        v    = rdata >> (8*sh);
        mask = (nb == 8) ? '1 : ((64'd1 << (8*nb)) - 64'd1);
        v    = v & mask;
        if (!i.uns && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [7:0] exp_strb(input ins_t i);
        int nb;
        nb = 1 << i.size;
        return 8'(((1 << nb) - 1) << int'(i.alu[2:0]));
    endfunction

    function automatic logic [63:0] exp_wdata(input ins_t i);
        logic [63:0] w;
        int          nb;
        nb = 1 << i.size;
        w  = '0;
        for (int k = 0; k < 8; k++) w[8*k +: 8] = i.sd[8*(k % nb) +: 8];
        return w;
    endfunction

    function automatic logic [WB_W-1:0] exp_wb(input ins_t i, input logic [63:0] rdata);
        logic [63:0] res;
        res = i.rd ? load_val(i, rdata) : i.alu;
        return {i.pc, res, i.rf, i.wa, i.cidx, i.cc, i.cdata, i.sys};
    endfunction

    function automatic ins_t rand_ins(input int kind);
        ins_t i;
        i.pc    = {$urandom(), $urandom()};
        i.alu   = {$urandom(), $urandom()};
        i.rf    = ($urandom_range(0, 1) == 1);
        i.wa    = 5'($urandom());
        i.cidx  = {$urandom(), $urandom()};
        i.cc    = 4'($urandom());
        i.cdata = {$urandom(), $urandom()};
        i.sys   = 2'($urandom());
        i.rd    = (kind == 1);
        i.wr    = (kind == 2);
        i.uns   = ($urandom_range(0, 1) == 1);
        i.size  = 2'($urandom_range(0, 3));
        i.sd    = {$urandom(), $urandom()};
        if (kind != 0) i.alu = (i.alu >> i.size) << i.size;
        return i;
    endfunction

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_acc   = 1'b0;
        m_done  = 1'b0;
        m_drain = 1'b0;
        m_rdata = '0;
        m_ins   = rand_ins(0);
    endtask

    task automatic idle_inputs();
        ex_to_mem_valid = 1'b0;
        wb_allow_in     = 1'b1;
        system_flush    = 1'b0;
        data_addr_ok    = 1'b0;
        data_data_ok    = 1'b0;
        data_rdata      = {$urandom(), $urandom()};
    endtask

    function automatic logic pend_req();
        return m_valid && ismem(m_ins) && !m_acc;
    endfunction

    function automatic logic pend_rsp();
        return (m_valid && m_acc && !m_done) || m_drain;
    endfunction

    // Called just after a negedge with this cycle's inputs already driven.
    task automatic tick();
        logic ready;
        logic e_allow;
        logic e_req;
        logic e_wbv;
        #1;
        ready   = !ismem(m_ins) || m_done;
        e_allow = !m_drain && (!m_valid || (ready && wb_allow_in));
        e_req   = pend_req();
        e_wbv   = m_valid && ready;
        chk("allow_in", 512'(mem_allow_in), 512'(e_allow));
        chk("data_req", 512'(data_req), 512'(e_req));
        chk("wb_valid", 512'(mem_to_wb_valid), 512'(e_wbv));
        if (e_req) begin
            chk("data_wr", 512'(data_wr), 512'(m_ins.wr));
            chk("data_addr", 512'(data_addr), 512'(m_ins.alu));
            if (m_ins.wr) begin
                chk("wstrb", 512'(data_wstrb), 512'(exp_strb(m_ins)));
                chk("wdata", 512'(data_wdata), 512'(exp_wdata(m_ins)));
            end
        end
        if (e_wbv) chk("wb_bus", 512'(mem_to_wb_bus), 512'(exp_wb(m_ins, m_rdata)));
        @(posedge clk);
        if (system_flush) begin
            if (pend_req() && data_addr_ok) m_drain = 1'b1;
            else if (m_valid && m_acc && !m_done && !data_data_ok) m_drain = 1'b1;
            else if (m_drain && data_data_ok) m_drain = 1'b0;
            m_valid = 1'b0;
        end else begin
            if (m_drain && data_data_ok) m_drain = 1'b0;
            if (pend_req() && data_addr_ok) begin
                m_acc = 1'b1;
            end else if (m_valid && m_acc && !m_done && data_data_ok) begin
                m_done  = 1'b1;
                m_rdata = data_rdata;
            end
            if (e_allow) begin
                m_valid = ex_to_mem_valid;
                if (ex_to_mem_valid) begin
                    m_ins  = ex_ins;
                    m_acc  = 1'b0;
                    m_done = 1'b0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic issue(input ins_t i);
        ex_ins          = i;
        ex_to_mem_valid = 1'b1;
        tick();
        ex_to_mem_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        idle_inputs();
        ex_ins = rand_ins(0);
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 512'(data_req), 512'(1'b0));
        chk("rst_wbv", 512'(mem_to_wb_valid), 512'(1'b0));
        chk("rst_allow", 512'(mem_allow_in), 512'(1'b1));
        chk("rst_wr", 512'(data_wr), 512'(1'b0));
        chk("rst_wstrb", 512'(data_wstrb), 512'(8'h00));
        @(negedge clk);
        rst = 1'b1;

        // three back-to-back non-memory ops
        ex_to_mem_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ex_ins = rand_ins(0);
            tick();
        end
        ex_to_mem_valid = 1'b0;
        tick();

        // LB from 0x1003, zero-wait memory
        ex_ins      = rand_ins(1);
        ex_ins.alu  = 64'h1003;
        ex_ins.size = 2'd0;
        ex_ins.uns  = 1'b0;
        issue(ex_ins);
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        data_rdata   = 64'h0000_0000_80AB_CDEF;
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("lb_valid", 512'(mem_to_wb_valid), 512'(1'b1));
        chk("lb_result", 512'(mem_to_wb_bus[WB_W-PCW-1 -: 64]), 512'(64'hFFFF_FFFF_FFFF_FF80));
        tick();

        // SH to 0x2006
        ex_ins      = rand_ins(2);
        ex_ins.alu  = 64'h2006;
        ex_ins.size = 2'd1;
        ex_ins.sd   = 64'h1234;
        issue(ex_ins);
        #1;
        chk("sh_wr", 512'(data_wr), 512'(1'b1));
        chk("sh_wstrb", 512'(data_wstrb), 512'(8'hC0));
        chk("sh_wdata", 512'(data_wdata), 512'(64'h1234_1234_1234_1234));
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        #1;
        chk("sh_result", 512'(mem_to_wb_bus[WB_W-PCW-1 -: 64]), 512'(64'h2006));
        tick();

        // LD with slow address and data handshakes
        ex_ins      = rand_ins(1);
        ex_ins.size = 2'd3;
        ex_ins.alu  = 64'h0000_0000_0000_3008;
        issue(ex_ins);
        repeat (3) tick();
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        repeat (2) tick();
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        tick();

        // flush while waiting for data, then a normal load
        issue(rand_ins(1));
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        system_flush = 1'b1;
        tick();
        system_flush    = 1'b0;
        ex_ins          = rand_ins(1);
        ex_to_mem_valid = 1'b1;
        #1;
        chk("drain_allow", 512'(mem_allow_in), 512'(1'b0));
        repeat (2) tick();
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        tick();
        ex_to_mem_valid = 1'b0;
        data_addr_ok    = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        data_data_ok = 1'b1;
        tick();
        data_data_ok = 1'b0;
        tick();

        // asynchronous reset while waiting for data
        issue(rand_ins(1));
        data_addr_ok = 1'b1;
        tick();
        data_addr_ok = 1'b0;
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", 512'(data_req), 512'(1'b0));
        chk("arst_wbv", 512'(mem_to_wb_valid), 512'(1'b0));
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        tick();

        // random traffic with random memory latency, stalls and flushes
        for (int c = 0; c < 3000; c++) begin
            ex_to_mem_valid = ($urandom_range(0, 9) < 7);
            ex_ins          = rand_ins(int'($urandom_range(0, 2)));
            wb_allow_in     = ($urandom_range(0, 3) != 0);
            system_flush    = ($urandom_range(0, 19) == 0);
            data_addr_ok    = pend_req() && ($urandom_range(0, 1) == 1);
            data_data_ok    = pend_rsp() && ($urandom_range(0, 2) == 0);
            data_rdata      = {$urandom(), $urandom()};
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
